// File: rtl/exp_align_stage.sv
// rtl/exp_align_stage.sv - FP add front end: exponent compare, significand swap and iterative alignment.
// Optional EXPALIGN_OVERLAP_EN: accept a new pair on the same edge the previous result is consumed.
module exp_align_stage #(
  parameter int EW  = 11,
  parameter int MW  = 53,
  parameter int SPC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW-1:0]   exp_a,
  input  logic [EW-1:0]   exp_b,
  input  logic [MW-1:0]   sig_a,
  input  logic [MW-1:0]   sig_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sel,
  output logic [EW-1:0]   exp_diff,
  output logic [MW-1:0]   sig_big,
  output logic [MW+2:0]   sig_aligned,
  output logic            busy
);

  localparam int SW = MW + 3;
  localparam int RW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] sh;
  logic [RW-1:0] rem;

  logic          sel_n;
  logic [EW-1:0] diff_n;
  logic [SW-1:0] sh_init;
  logic [RW-1:0] rem_init;
  logic [RW-1:0] k;
  logic [SW-1:0] shifted;
  logic [SW-1:0] lost_mask;
  logic [SW-1:0] sh_next;
  logic [RW-1:0] rem_next;
  logic          accept;

`ifdef EXPALIGN_OVERLAP_EN
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    sel_n   = (exp_b > exp_a);
    // Subtract in the ordered direction so the magnitude never wraps.
    diff_n  = sel_n ? (exp_b - exp_a) : (exp_a - exp_b);
    sh_init = {(sel_n ? sig_a : sig_b), 3'b000};
    if (32'(diff_n) >= SW) rem_init = RW'(SW);
    else                   rem_init = RW'(diff_n);
  end

  always_comb begin
    k         = (rem > RW'(SPC)) ? RW'(SPC) : rem;
    shifted   = sh >> k;
    lost_mask = ~({SW{1'b1}} << k);
    // Old bit0 is the running sticky; fold in everything shifted out this step.
    sh_next   = {shifted[SW-1:1], shifted[0] | (|(sh & lost_mask)) | sh[0]};
    rem_next  = rem - k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sh          <= '0;
      rem         <= '0;
      out_valid   <= 1'b0;
      sel         <= 1'b0;
      exp_diff    <= '0;
      sig_big     <= '0;
      sig_aligned <= '0;
      busy        <= 1'b0;
    end else if (accept) begin
      sel      <= sel_n;
      exp_diff <= diff_n;
      sig_big  <= sel_n ? sig_b : sig_a;
      sh       <= sh_init;
      rem      <= rem_init;
      busy     <= 1'b1;
      if (rem_init == '0) begin
        state       <= DONE;
        out_valid   <= 1'b1;
        sig_aligned <= sh_init;
      end else begin
        state     <= SHIFT;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        SHIFT: begin
          sh  <= sh_next;
          rem <= rem_next;
          if (rem_next == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            sig_aligned <= sh_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exp_align_stage.md
Name: exp_align_stage

Overview:
- Floating-point add front end: compares two EW-bit exponents and drives the select that steers the downstream 11-bit 2:1 exponent mux (sel=1 picks operand b).
- Swaps the significands and iteratively right-aligns the smaller one by the exponent difference, with guard, round and sticky bits.
- Uses a valid/ready handshake on both sides; the result feeds the significand adder.

Parameters:
- EW, 11: exponent width.
- MW, 53: significand width, hidden bit included.
- SPC, 8: maximum right-shift positions per cycle (1..MW+3).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- exp_a  in  EW  exponent of operand a.
- exp_b  in  EW  exponent of operand b.
- sig_a  in  MW  significand of operand a.
- sig_b  in  MW  significand of operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sel  out  1  select for the exponent mux; 1 when exp_b > exp_a.
- exp_diff  out  EW  |exp_a - exp_b|, unsaturated.
- sig_big  out  MW  significand of the larger operand.
- sig_aligned  out  MW+3  smaller significand, right-shifted; bits {G,R,S} in [2:0].
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. While reset is high, inputs are ignored.
- Reset values: state IDLE; out_valid=0, sel=0, exp_diff=0, sig_big=0, sig_aligned=0, busy=0. in_ready=1 from the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE); see the optional feature for the exception.
- Accept occurs when in_valid && in_ready, evaluated at the clock edge. On accept, register:
  - sel = (exp_b > exp_a). On a tie sel=0, so operand a is treated as the larger.
  - exp_diff = |exp_a - exp_b|, computed in EW+1 bits with no wrap.
  - sig_big = sel ? sig_b : sig_a.
  - sh = {sel ? sig_a : sig_b, 3'b000}.
  - rem = min(exp_diff, MW+3).
  - Next state: DONE if rem==0, otherwise SHIFT.
- SHIFT, each cycle:
  - k = min(rem, SPC).
  - sh = (sh >> k), with bit0 |= OR of the k bits shifted out and OR of the old bit0. Sticky accumulates across steps.
  - rem -= k. Go to DONE when rem reaches 0.
- Saturation: if exp_diff >= MW+3, all bits are shifted out; sig_aligned = 1 if the small significand was nonzero, else 0.
- DONE: out_valid=1 and sig_aligned=sh. All outputs are held stable until out_ready=1. On out_valid && out_ready, go to IDLE and clear out_valid.
- Latency from the accept edge to out_valid visible: 1 + ceil(rem/SPC) cycles. This is 1 cycle for equal exponents.
- sel, exp_diff and sig_big are valid from the cycle after accept and remain constant until the next accept.
- Reset mid-operation (SHIFT or DONE): the in-flight operation is dropped, the block returns to the reset values and no output is produced.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: EXPALIGN_OVERLAP_EN.
- Defined: in_ready = (state==IDLE) || (state==DONE && out_ready). A new pair can be accepted on the same edge the result is consumed, so back-to-back operation has no IDLE bubble. The new result's fields overwrite the old ones at that edge.
- Undefined: in_ready=1 only in IDLE, so there is at least one idle cycle between operations.

Test Plan (MW=8, EW=11 build unless noted):
- Basic alignment, SPC=8: exp_a=12, exp_b=7, sig_a=0x80, sig_b=0xC5 -> sel=0, exp_diff=5, sig_big=0x80, sig_aligned=0x031 (sticky=1); out_valid 2 cycles after accept.
- Stepped shift, SPC=2, same stimulus -> shift steps of 2, 2, 1; out_valid 4 cycles after accept; sig_aligned=0x031.
- Tie: exp_a=exp_b=50, sig_a=0x91, sig_b=0xA3 -> sel=0, exp_diff=0, sig_aligned=0x518; latency 1.
- Saturation: exp_a=0, exp_b=100, sig_a=0x01 -> sel=1, exp_diff=100, sig_aligned=0x001. With sig_a=0x00 -> sig_aligned=0x000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> all outputs stable, in_ready=0. Then pulse out_ready -> IDLE next cycle, in_ready=1. With EXPALIGN_OVERLAP_EN, a pair presented during that pulse is accepted with no idle cycle.
- Reset mid-SHIFT: SPC=1, exp_diff=9, assert reset on the 3rd shift cycle -> next cycle all outputs are 0 and in_ready=1; out_valid never asserts for the dropped operation.
